// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline for LATENCY cycles per load/store.
// Optional DMEM_STATS_EN adds saturating read/write/error counters.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [31:0] memaddr_i,
    input  logic [31:0] writedata_i,
    output logic [31:0] memdata_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] rd_cnt_o,
    output logic [15:0] wr_cnt_o,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    logic [31:0]       mem [DEPTH_WORDS];

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rd_q;
    logic              wr_q;
    logic              cap_err_q;
    logic              ack_q;
    logic              err_q;
    logic [31:0]       memdata_q;

    logic              req;
    logic              in_err;
    logic              accept;
    logic              do_access;
    logic              mem_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_rd;
    logic              acc_wr;
    logic              acc_err;

    assign req    = memread_i | memwrite_i;
    assign in_err = (memaddr_i[1:0] != 2'b00)
                 || ((memaddr_i >> (ADDR_W + 2)) != 32'd0)
                 || (memread_i && memwrite_i);
    assign accept = (state_q == StIdle) && req;

    // With LATENCY==1 the access happens on the accept edge, so it uses the live inputs.
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_rd    = rd_q;
        acc_wr    = wr_q;
        acc_err   = cap_err_q;
        if (state_q == StIdle) begin
            acc_addr  = memaddr_i[ADDR_W+1:2];
            acc_wdata = writedata_i;
            acc_rd    = memread_i;
            acc_wr    = memwrite_i;
            acc_err   = in_err;
        end
    end

    assign do_access = (accept && (LATENCY == 1)) || ((state_q == StBusy) && (cnt_q == 4'd1));
    assign mem_we    = do_access && acc_wr && !acc_err && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cap_err_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            memdata_q <= 32'd0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q    <= memaddr_i[ADDR_W+1:2];
                        wdata_q   <= writedata_i;
                        rd_q      <= memread_i;
                        wr_q      <= memwrite_i;
                        cap_err_q <= in_err;
                        cnt_q     <= 4'(LATENCY - 1);
                        state_q   <= (LATENCY == 1) ? StDone : StBusy;
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (do_access) begin
                ack_q <= 1'b1;
                err_q <= acc_err;
                if (acc_rd) begin
                    memdata_q <= acc_err ? 32'd0 : mem[acc_addr];
                end
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    assign stall_o   = (state_q == StBusy) || accept;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign memdata_o = memdata_q;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_cnt_q  <= 16'd0;
            wr_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else if (state_q == StDone) begin
            if (cap_err_q) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end else if (rd_q) begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end else if (wr_q) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign err_cnt_o = err_cnt_q;
`endif

endmodule
